// File: rtl/instruction_fetch_pkg.sv
// Shared widths and payload types for the instruction fetch unit.
package instruction_fetch_pkg;

  localparam int unsigned DATA_W      = 16;
  localparam int unsigned FETCH_DEPTH = 4;

  typedef logic [DATA_W-1:0] word_t;

  // One prefetched instruction tagged with the PC it was fetched from.
  typedef struct packed {
    word_t instr;
    word_t pc;
  } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction memory and decode-side signals of the fetch unit.
interface instruction_fetch_if;
  import instruction_fetch_pkg::*;

  word_t imem_addr;
  word_t imem_data;
  logic  redirect;
  word_t redirect_pc;
  logic  inst_valid;
  logic  inst_ready;
  word_t inst;
  word_t inst_pc;

  modport master (
    output imem_addr, inst_valid, inst, inst_pc,
    input  imem_data, redirect, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_addr, inst_valid, inst, inst_pc,
    output imem_data, redirect, redirect_pc, inst_ready
  );

endinterface

// File: rtl/instruction_fetch_fetch_fifo.sv
// Prefetch FIFO of {instr, pc} entries with synchronous flush.
module fetch_fifo
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = FETCH_DEPTH
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       push_i,
  input  fetch_entry_t               push_entry_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output fetch_entry_t               head_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;

  // Pointer and occupancy update; flush empties the queue.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents need no reset since count gates validity.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_entry_i;
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instruction_fetch.sv
// Fetch unit: PC generation, one-cycle memory latency tracking, redirect/flush.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = FETCH_DEPTH,
  parameter word_t       RESET_PC = DATA_W'(0)
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  instruction_fetch_if.master  bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 1;

  word_t            fetch_pc_q, fetch_pc_d;
  word_t            inflight_pc_q, inflight_pc_d;
  logic             inflight_q, inflight_d;
  logic [CNT_W-1:0] count;
  logic [OCC_W-1:0] occupancy;
  logic             issue;
  logic             push;
  logic             pop;
  fetch_entry_t     head;
  fetch_entry_t     push_entry;

  // Issue/response/pop decisions and next PC; redirect overrides issue.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = 1'b0;
    occupancy     = OCC_W'(count) + OCC_W'(inflight_q);
    issue         = !bus.redirect && (occupancy < OCC_W'(DEPTH));
    push          = inflight_q && !bus.redirect;
    pop           = bus.inst_valid && bus.inst_ready && !bus.redirect;
    push_entry    = '{instr: bus.imem_data, pc: inflight_pc_q};
    if (bus.redirect) begin
      fetch_pc_d = bus.redirect_pc;
    end else if (issue) begin
      inflight_d    = 1'b1;
      inflight_pc_d = fetch_pc_q;
      fetch_pc_d    = fetch_pc_q + DATA_W'(1);
    end
  end

  // PC and inflight tracking registers.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .flush_i      (bus.redirect),
    .count_o      (count),
    .head_o       (head)
  );

  assign bus.imem_addr  = fetch_pc_q;
  assign bus.inst_valid = (count != '0);
  assign bus.inst       = head.instr;
  assign bus.inst_pc    = head.pc;

  // Occupancy including the outstanding request never exceeds the FIFO.
  a_count_le_depth : assert property (@(posedge clk_i) disable iff (!rst_n_i)
    count <= CNT_W'(DEPTH));
  a_occ_le_depth : assert property (@(posedge clk_i) disable iff (!rst_n_i)
    occupancy <= OCC_W'(DEPTH));

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch with a registered-address memory model.
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic ready_w;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [31:0] sb_q[$];   // {inst, pc} expected from the main DUT
  logic [15:0] sbw_q[$];  // pc expected from the wrap-around DUT

  instruction_fetch_if bif ();
  instruction_fetch_if wif ();

  instruction_fetch dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bif)
  );

  instruction_fetch #(.RESET_PC(16'hFFFE)) dut_w (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (wif)
  );

  always #5 clk = ~clk;

  // Registered-address instruction memory: mem[a] = A000 + a.
  always @(posedge clk) begin
    bif.imem_data <= 16'hA000 + bif.imem_addr;
    wif.imem_data <= 16'hA000 + wif.imem_addr;
  end

  assign wif.redirect    = 1'b0;
  assign wif.redirect_pc = 16'h0000;
  assign wif.inst_ready  = ready_w;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic void sb_push(input logic [15:0] pc);
    logic [15:0] instr;
    instr = 16'hA000 + pc;
    sb_q.push_back({instr, pc});
  endfunction

  // Compare every accepted instruction against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && bif.inst_valid && bif.inst_ready && !bif.redirect) begin
      check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        logic [31:0] e;
        e = sb_q.pop_front();
        check("inst", 32'(bif.inst), 32'(e[31:16]));
        check("inst_pc", 32'(bif.inst_pc), 32'(e[15:0]));
      end
    end
    if (rst_n && wif.inst_valid && ready_w) begin
      check("w_sb_nonempty", 32'(sbw_q.size() != 0), 32'd1);
      if (sbw_q.size() != 0) check("w_inst_pc", 32'(wif.inst_pc), 32'(sbw_q.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    tick();
    rst_n = 1'b0;
    bif.redirect = 1'b0;
    bif.redirect_pc = 16'h0000;
    bif.inst_ready = 1'b0;
    ready_w = 1'b0;
    tick();
    tick();
    sb_q.delete();
    sbw_q.delete();
  endtask

  // Release reset and stream 20 instructions with ready held high.
  task automatic run_stream(input string tag);
    for (int i = 0; i < 20; i++) sb_push(16'(i));
    for (int k = 0; k < 22; k++) begin
      tick();
      rst_n = 1'b1;
      bif.inst_ready = 1'b1;
      if (k == 0) check({tag, "_addr0"}, 32'(bif.imem_addr), 32'h0000);
      @(negedge clk);
      if (k == 0) check({tag, "_count0"}, 32'(dut.u_fifo.count_q), 32'd0);
      check({tag, "_valid"}, 32'(bif.inst_valid), (k < 2) ? 32'd0 : 32'd1);
    end
    tick();
    bif.inst_ready = 1'b0;
    check({tag, "_drained"}, 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    bif.redirect = 1'b0;
    bif.redirect_pc = 16'h0000;
    bif.inst_ready = 1'b0;
    ready_w = 1'b0;

    // Reset state
    reset_dut();
    @(negedge clk);
    check("rst_valid", 32'(bif.inst_valid), 32'd0);
    check("rst_addr", 32'(bif.imem_addr), 32'h0000);
    check("rst_addr_w", 32'(wif.imem_addr), 32'h0000FFFE);

    // 1: streaming from reset
    run_stream("s1");

    // 2: backpressure fills the FIFO, then drains in order
    reset_dut();
    for (int k = 0; k < 10; k++) begin
      tick();
      rst_n = 1'b1;
      @(negedge clk);
    end
    check("s2_addr", 32'(bif.imem_addr), 32'h0004);
    check("s2_count", 32'(dut.u_fifo.count_q), 32'd4);
    check("s2_inflight", 32'(dut.inflight_q), 32'd0);
    check("s2_valid", 32'(bif.inst_valid), 32'd1);
    for (int i = 0; i < 5; i++) sb_push(16'(i));
    for (int k = 10; k < 15; k++) begin
      tick();
      bif.inst_ready = 1'b1;
      @(negedge clk);
    end
    tick();
    bif.inst_ready = 1'b0;
    check("s2_drained", 32'(sb_q.size()), 32'd0);

    // 3: redirect with 3 entries buffered plus one inflight
    reset_dut();
    for (int k = 0; k < 4; k++) begin
      tick();
      rst_n = 1'b1;
      @(negedge clk);
    end
    tick();
    bif.redirect = 1'b1;
    bif.redirect_pc = 16'h0010;
    sb_q.delete();
    for (int i = 0; i < 5; i++) sb_push(16'h0010 + 16'(i));
    @(negedge clk);
    check("s3_count", 32'(dut.u_fifo.count_q), 32'd3);
    check("s3_inflight", 32'(dut.inflight_q), 32'd1);
    for (int k = 1; k <= 7; k++) begin
      tick();
      bif.redirect = 1'b0;
      bif.inst_ready = 1'b1;
      @(negedge clk);
      check("s3_valid", 32'(bif.inst_valid), (k < 3) ? 32'd0 : 32'd1);
    end
    tick();
    bif.inst_ready = 1'b0;
    check("s3_drained", 32'(sb_q.size()), 32'd0);

    // 4: redirect and ready together voids the pop
    reset_dut();
    sb_push(16'h0000);
    sb_push(16'h0001);
    for (int k = 0; k < 4; k++) begin
      tick();
      rst_n = 1'b1;
      bif.inst_ready = 1'b1;
      @(negedge clk);
    end
    tick();
    check("s4_pre", 32'(sb_q.size()), 32'd0);
    bif.redirect = 1'b1;
    bif.redirect_pc = 16'h0020;
    for (int i = 0; i < 3; i++) sb_push(16'h0020 + 16'(i));
    @(negedge clk);
    check("s4_valid_r", 32'(bif.inst_valid), 32'd1);
    check("s4_head_pc", 32'(bif.inst_pc), 32'h0002);
    for (int k = 1; k <= 5; k++) begin
      tick();
      bif.redirect = 1'b0;
      @(negedge clk);
      check("s4_valid", 32'(bif.inst_valid), (k < 3) ? 32'd0 : 32'd1);
    end
    tick();
    bif.inst_ready = 1'b0;
    check("s4_drained", 32'(sb_q.size()), 32'd0);

    // 5: PC wraps from FFFF to 0000
    reset_dut();
    sbw_q.push_back(16'hFFFE);
    sbw_q.push_back(16'hFFFF);
    sbw_q.push_back(16'h0000);
    sbw_q.push_back(16'h0001);
    for (int k = 0; k < 6; k++) begin
      tick();
      rst_n = 1'b1;
      ready_w = 1'b1;
      @(negedge clk);
      check("s5_valid", 32'(wif.inst_valid), (k < 2) ? 32'd0 : 32'd1);
    end
    tick();
    ready_w = 1'b0;
    check("s5_drained", 32'(sbw_q.size()), 32'd0);

    // 6: one-cycle reset with a full FIFO, then restart
    reset_dut();
    for (int k = 0; k < 10; k++) begin
      tick();
      rst_n = 1'b1;
      @(negedge clk);
    end
    check("s6_full", 32'(dut.u_fifo.count_q), 32'd4);
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    run_stream("s6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Initiator side of the instruction memory interface.
- Drives the word address into the registered-address instruction memory and accounts for its one-cycle read latency.
- Buffers returned instruction words, each tagged with its PC, in a small prefetch FIFO.
- Presents them to the decode stage over a valid/ready handshake, and supports branch redirect with flush.

Parameters:
DEPTH, 4, prefetch FIFO entries; power of 2, at least 2.
RESET_PC, `DATA_W'h0000, fetch PC loaded on reset.

Ports:
CLK  input  1  clock; all state updates on posedge.
RST_N  input  1  synchronous active-low reset.
IMEM_ADDR  output  `DATA_W  word address to instruction memory; memory samples it on every posedge.
IMEM_DATA  input  `DATA_W  instruction word for the address sampled at the previous posedge.
REDIRECT  input  1  branch/jump taken; flush and refetch.
REDIRECT_PC  input  `DATA_W  new fetch PC, valid when REDIRECT=1.
INST_VALID  output  1  FIFO head holds a valid instruction.
INST_READY  input  1  decode accepts the head this cycle.
INST  output  `DATA_W  head instruction word.
INST_PC  output  `DATA_W  PC of head instruction.

Behaviour:
- State:
  - fetch_pc (`DATA_W).
  - inflight flag and inflight_pc: a request was sampled by memory last edge.
  - FIFO storage with count (0..DEPTH).
- IMEM_ADDR = fetch_pc, combinational from the register.
- Reset (RST_N=0 at posedge):
  - fetch_pc <= RESET_PC, inflight <= 0, count <= 0, FIFO pointers <= 0.
  - INST_VALID = 0; INST and INST_PC are don't-care.
  - Reset mid-operation discards everything, including any inflight word.
- Issue condition: issue = RST_N & ~REDIRECT & ((count + inflight) < DEPTH).
  - A pop in the same cycle is not credited (conservative; still sustains 1 instr/cycle for DEPTH >= 3).
- On issue:
  - inflight <= 1, inflight_pc <= fetch_pc, fetch_pc <= fetch_pc + 1.
  - The increment is modulo 2^`DATA_W, so FFFF wraps to 0000.
- No issue: inflight <= 0 and fetch_pc holds. The memory still samples IMEM_ADDR, but its response is ignored.
- Response: if inflight and not REDIRECT, push {IMEM_DATA, inflight_pc} into the FIFO at the posedge.
- Latency:
  - Request issued in cycle c gives data on IMEM_DATA in cycle c+1, pushed at the end of c+1.
  - INST_VALID in cycle c+2 if the FIFO was empty.
  - First instruction after reset release: INST_VALID in cycle 2.
- Handshake:
  - Pop when INST_VALID & INST_READY & ~REDIRECT.
  - INST and INST_PC are stable while INST_VALID=1 and INST_READY=0.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - The push never overflows, by the issue condition.
  - Pop on empty is impossible, since it is gated by INST_VALID.
- REDIRECT (highest priority after reset):
  - At posedge: fetch_pc <= REDIRECT_PC, count <= 0 (flush), inflight <= 0.
  - The inflight response is discarded and any pop that cycle is void.
  - First issue of REDIRECT_PC is in cycle r+1; INST_VALID rises in cycle r+3.
  - INST_VALID is low in r+1 and r+2.
- Back-to-back REDIRECT: the last one wins; each cycle with REDIRECT=1 suppresses issue.
- Assertions: count <= DEPTH; (count + inflight) <= DEPTH.

Decomposition:
- def.v (shared include): reuse `DATA_W and `MEM_WORD; add `FETCH_DEPTH as the default for DEPTH.
- One sub-module, fetch_fifo:
  - Synchronous FIFO of {`DATA_W instr, `DATA_W pc} with push, pop, flush, count, head outputs.
  - Same CLK/RST_N scheme.
- Top level holds the PC, inflight tracking, and issue/redirect control.

Test Plan:
- Bench instruction memory model: same registered-address behaviour, preloaded mem[i] = 16'hA000 + i.
1. Reset release, INST_READY=1 -> INST_VALID first high in cycle 2 with INST=A000, INST_PC=0000; then A001, A002, ... one per cycle with no bubbles.
2. INST_READY=0 for 10 cycles after reset -> FIFO holds A000..A003, fetch_pc stops at 0004, count=4, inflight=0; READY=1 -> A000..A003, A004 in order, no duplicate or gap.
3. FIFO holds 3 entries + inflight, REDIRECT=1, REDIRECT_PC=0010 -> INST_VALID=0 in r+1 and r+2; cycle r+3 gives INST=A010, INST_PC=0010; no A00x after the redirect.
4. REDIRECT and INST_READY both high in the same cycle with INST_VALID=1 -> the head is not counted as consumed; next delivered INST_PC is REDIRECT_PC.
5. RESET_PC=FFFE, READY=1 -> INST_PC sequence FFFE, FFFF, 0000, 0001 (check PC only).
6. RST_N=0 for 1 cycle with FIFO full -> next cycle INST_VALID=0, IMEM_ADDR=RESET_PC, count=0; restart matches scenario 1 timing.
